// File: rtl/nibbler_pkg.sv
// Shared NibblER definitions for the fetch/decode front end.
// This package holds the sequencer state encoding and the jump opcodes.
package nibbler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      FETCH2 = 2'd2,
      EXEC   = 2'd3
   } fetch_state_t;

   localparam logic [3:0] OPC_JC  = 4'h0;
   localparam logic [3:0] OPC_JNC = 4'h1;
   localparam logic [3:0] OPC_JZ  = 4'h8;
   localparam logic [3:0] OPC_JNZ = 4'h9;
   localparam logic [3:0] OPC_JMP = 4'hA;

   function automatic logic is_jump(input logic [3:0] opc);
      return (opc == OPC_JC)  || (opc == OPC_JNC) || (opc == OPC_JZ) ||
             (opc == OPC_JNZ) || (opc == OPC_JMP);
   endfunction

endpackage

// File: rtl/fetch_sequencer_jump_cond.sv
// Branch-taken decision from a jump opcode and the ALU flags.
// Purely combinational so the debugger can reuse it on its own.
module jump_cond
   import nibbler_pkg::*;
(
   input  logic [3:0] opc,
   input  logic       c_flag,
   input  logic       z_flag,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (opc)
         OPC_JMP: taken = 1'b1;
         OPC_JC:  taken = c_flag;
         OPC_JNC: taken = ~c_flag;
         OPC_JZ:  taken = z_flag;
         OPC_JNZ: taken = ~z_flag;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: reads program bytes at the PC, steers
// incPC/loadPC back to the PC and hands 1-byte instructions to execute.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | read first instruction byte at addr
// FETCH2 | read jump low byte, resolve branch
// EXEC   | instruction presented to execute stage
module fetch_sequencer
   import nibbler_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              incPC,
   output logic              loadPC,
   output logic [ADDR_W-1:0] newaddr,
   input  logic              c_flag,
   input  logic              z_flag,
   input  logic              stall,
   output logic [3:0]        instr,
   output logic [3:0]        oprnd,
   output logic              instr_valid,
   output logic              phase
);

   fetch_state_t      state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              mem_req_q, mem_req_d;
   logic              phase_q, phase_d;
   logic              instr_valid_q, instr_valid_d;
   logic [3:0]        instr_q, instr_d;
   logic [3:0]        oprnd_q, oprnd_d;
   logic              inc_pc, load_pc;
   logic              rd_ok;
   logic              taken;
   logic [ADDR_W-1:0] target;

   jump_cond u_jump_cond (
      .opc    (ir_q[DATA_W-1 -: 4]),
      .c_flag (c_flag),
      .z_flag (z_flag),
      .taken  (taken)
   );

   assign rd_ok  = mem_valid & mem_req_q;
   assign target = ADDR_W'({ir_q[3:0], mem_rdata});

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      mem_req_d     = mem_req_q;
      phase_d       = phase_q;
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      oprnd_d       = oprnd_q;
      inc_pc        = 1'b0;
      load_pc       = 1'b0;
      case (state_q)
         IDLE: begin
            state_d   = FETCH;
            mem_req_d = 1'b1;
         end
         FETCH: begin
            if (rd_ok) begin
               ir_d   = mem_rdata;
               inc_pc = 1'b1;
               if (is_jump(mem_rdata[DATA_W-1 -: 4])) begin
                  state_d = FETCH2;
               end else begin
                  state_d       = EXEC;
                  mem_req_d     = 1'b0;
                  phase_d       = 1'b1;
                  instr_valid_d = 1'b1;
                  instr_d       = mem_rdata[DATA_W-1 -: 4];
                  oprnd_d       = mem_rdata[3:0];
               end
            end
         end
         FETCH2: begin
            // Flags are used as seen in the cycle the low byte arrives.
            if (rd_ok) begin
               load_pc = taken;
               inc_pc  = ~taken;
               state_d = FETCH;
            end
         end
         EXEC: begin
            if (!stall) begin
               state_d   = FETCH;
               mem_req_d = 1'b1;
               phase_d   = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            phase_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= IDLE;
         ir_q          <= '0;
         mem_req_q     <= 1'b0;
         phase_q       <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         oprnd_q       <= '0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         mem_req_q     <= mem_req_d;
         phase_q       <= phase_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         oprnd_q       <= oprnd_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_req_q ? addr : '0;
   assign incPC       = inc_pc;
   assign loadPC      = load_pc;
   assign newaddr     = load_pc ? target : '0;
   assign instr       = instr_q;
   assign oprnd       = oprnd_q;
   assign instr_valid = instr_valid_q;
   assign phase       = phase_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a PC model and a wait-state ROM.
module tb_fetch_sequencer;

   localparam int EV_INC   = 0;
   localparam int EV_LOAD  = 1;
   localparam int EV_INSTR = 2;

   localparam int S_MEMREQ = 0;
   localparam int S_INC    = 1;
   localparam int S_LOAD   = 2;
   localparam int S_PHASE  = 3;
   localparam int S_IVAL   = 4;
   localparam int S_PC     = 5;
   localparam int S_INSTR  = 6;
   localparam int S_OPRND  = 7;
   localparam int S_NEWA   = 8;
   localparam int S_MADDR  = 9;
   localparam int S_QSIZE  = 10;

   logic        clk = 1'b0;
   logic        Rst = 1'b0;
   logic [11:0] addr;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_valid;
   logic        incPC, loadPC;
   logic [11:0] newaddr;
   logic        c_flag = 1'b0;
   logic        z_flag = 1'b0;
   logic        stall  = 1'b0;
   logic [3:0]  instr, oprnd;
   logic        instr_valid, phase;

   logic [7:0]  rom     [4096];
   logic        rom_def [4096];
   int          wait_n  = 0;
   int          wcnt;
   logic [11:0] pc_init = 12'h000;

   int          n_total = 0;
   int          n_pass  = 0;

   int          ev_kind_q [$];
   logic [11:0] ev_val_q  [$];
   string       ck_name_q [$];
   int          ck_sel_q  [$];
   logic [11:0] ck_val_q  [$];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk         (clk),
      .Rst         (Rst),
      .addr        (addr),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .incPC       (incPC),
      .loadPC      (loadPC),
      .newaddr     (newaddr),
      .c_flag      (c_flag),
      .z_flag      (z_flag),
      .stall       (stall),
      .instr       (instr),
      .oprnd       (oprnd),
      .instr_valid (instr_valid),
      .phase       (phase)
   );

   // PC model: reset loads pc_init, load wins over increment, 12-bit wrap.
   always @(posedge clk or negedge Rst) begin
      if (!Rst)        addr <= pc_init;
      else if (loadPC) addr <= newaddr;
      else if (incPC)  addr <= addr + 12'd1;
   end

   // ROM answers after wait_n cycles, and never for undefined addresses.
   assign mem_rdata = rom[mem_addr];
   assign mem_valid = mem_req && rom_def[mem_addr] && (wcnt >= wait_n);

   always @(posedge clk or negedge Rst) begin
      if (!Rst)                      wcnt <= 0;
      else if (!mem_req || mem_valid) wcnt <= 0;
      else                           wcnt <= wcnt + 1;
   end

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [11:0] sample(input int sel);
      case (sel)
         S_MEMREQ: return {11'd0, mem_req};
         S_INC:    return {11'd0, incPC};
         S_LOAD:   return {11'd0, loadPC};
         S_PHASE:  return {11'd0, phase};
         S_IVAL:   return {11'd0, instr_valid};
         S_PC:     return addr;
         S_INSTR:  return {8'd0, instr};
         S_OPRND:  return {8'd0, oprnd};
         S_NEWA:   return newaddr;
         S_MADDR:  return mem_addr;
         S_QSIZE:  return 12'(ev_kind_q.size());
         default:  return 12'hxxx;
      endcase
   endfunction

   task automatic pop_event(input string nm, input int kind, input logic [11:0] act);
      int          k;
      logic [11:0] v;
      if (ev_kind_q.size() == 0) begin
         check({nm, "_unexpected"}, act, 12'hEEE);
      end else begin
         k = ev_kind_q.pop_front();
         v = ev_val_q.pop_front();
         check({nm, "_kind"}, 12'(kind), 12'(k));
         check({nm, "_value"}, act, v);
      end
   endtask

   // Monitor: consumes DUT strobes against the event queue, then services
   // the point checks the stimulus process requested for this cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (incPC)       pop_event("incPC", EV_INC, addr);
         if (loadPC)      pop_event("loadPC", EV_LOAD, newaddr);
         if (instr_valid) pop_event("instr", EV_INSTR, {3'd0, phase, instr, oprnd});
         while (ck_sel_q.size() > 0) begin
            string       nm;
            int          sel;
            logic [11:0] v;
            nm  = ck_name_q.pop_front();
            sel = ck_sel_q.pop_front();
            v   = ck_val_q.pop_front();
            check(nm, sample(sel), v);
         end
      end
   end

   task automatic expect_ev(input int kind, input logic [11:0] v);
      ev_kind_q.push_back(kind);
      ev_val_q.push_back(v);
   endtask

   task automatic req(input string nm, input int sel, input logic [11:0] v);
      ck_name_q.push_back(nm);
      ck_sel_q.push_back(sel);
      ck_val_q.push_back(v);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in its IDLE cycle, one time unit after a rising edge.
   task automatic reset_to(input logic [11:0] pc, input int wn);
      cyc(1);
      pc_init = pc;
      wait_n  = wn;
      Rst     = 1'b0;
      cyc(2);
      Rst     = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) begin
         rom[i]     = 8'h00;
         rom_def[i] = 1'b0;
      end
      rom[12'h000] = 8'h5C; rom_def[12'h000] = 1'b1;
      rom[12'h010] = 8'hA3; rom_def[12'h010] = 1'b1;
      rom[12'h011] = 8'h59; rom_def[12'h011] = 1'b1;
      rom[12'h020] = 8'h82; rom_def[12'h020] = 1'b1;
      rom[12'h021] = 8'h00; rom_def[12'h021] = 1'b1;
      rom[12'h030] = 8'h91; rom_def[12'h030] = 1'b1;
      rom[12'h031] = 8'h23; rom_def[12'h031] = 1'b1;
      rom[12'h040] = 8'h07; rom_def[12'h040] = 1'b1;
      rom[12'h041] = 8'hFE; rom_def[12'h041] = 1'b1;

      // Reset asserted while a slow fetch is outstanding.
      reset_to(12'h000, 3);
      req("idle_memreq", S_MEMREQ, 12'h0);
      req("idle_phase", S_PHASE, 12'h0);
      cyc(1);
      req("fetch_memreq", S_MEMREQ, 12'h1);
      req("fetch_wait_inc", S_INC, 12'h0);
      cyc(1);
      #2;
      Rst = 1'b0;
      #1;
      req("rst_memreq", S_MEMREQ, 12'h0);
      req("rst_inc", S_INC, 12'h0);
      req("rst_load", S_LOAD, 12'h0);
      req("rst_phase", S_PHASE, 12'h0);
      req("rst_ival", S_IVAL, 12'h0);
      req("rst_newaddr", S_NEWA, 12'h0);
      req("rst_instr", S_INSTR, 12'h0);
      cyc(1);
      Rst = 1'b1;
      expect_ev(EV_INC, 12'h000);
      expect_ev(EV_INSTR, 12'h15C);
      req("rel_idle_memreq", S_MEMREQ, 12'h0);
      cyc(1);
      req("rel_fetch_memreq", S_MEMREQ, 12'h1);
      cyc(8);
      req("rel_pc", S_PC, 12'h001);
      req("rel_instr_held", S_INSTR, 12'h5);
      req("rel_oprnd_held", S_OPRND, 12'hC);
      req("rel_phase", S_PHASE, 12'h0);
      req("rel_qempty", S_QSIZE, 12'h0);

      // One-byte instruction, zero-wait memory.
      reset_to(12'h000, 0);
      expect_ev(EV_INC, 12'h000);
      expect_ev(EV_INSTR, 12'h15C);
      cyc(1);
      req("b1_inc", S_INC, 12'h1);
      req("b1_maddr", S_MADDR, 12'h000);
      cyc(1);
      req("b1_ival", S_IVAL, 12'h1);
      req("b1_phase", S_PHASE, 12'h1);
      req("b1_instr", S_INSTR, 12'h5);
      req("b1_oprnd", S_OPRND, 12'hC);
      req("b1_pc", S_PC, 12'h001);
      cyc(1);
      req("b1_next_phase", S_PHASE, 12'h0);
      req("b1_next_ival", S_IVAL, 12'h0);
      req("b1_next_memreq", S_MEMREQ, 12'h1);
      req("b1_qempty", S_QSIZE, 12'h0);

      // JMP 0x359.
      reset_to(12'h010, 0);
      expect_ev(EV_INC, 12'h010);
      expect_ev(EV_LOAD, 12'h359);
      cyc(1);
      req("jmp_inc", S_INC, 12'h1);
      cyc(1);
      req("jmp_maddr2", S_MADDR, 12'h011);
      req("jmp_load", S_LOAD, 12'h1);
      req("jmp_inc2", S_INC, 12'h0);
      req("jmp_newaddr", S_NEWA, 12'h359);
      cyc(3);
      req("jmp_pc", S_PC, 12'h359);
      req("jmp_phase", S_PHASE, 12'h0);
      req("jmp_qempty", S_QSIZE, 12'h0);

      // JZ with z=0: falls through, two increments.
      z_flag = 1'b0;
      reset_to(12'h020, 0);
      expect_ev(EV_INC, 12'h020);
      expect_ev(EV_INC, 12'h021);
      cyc(4);
      req("jz_pc", S_PC, 12'h022);
      req("jz_qempty", S_QSIZE, 12'h0);

      // JNZ with z=0: taken to 0x123.
      reset_to(12'h030, 0);
      expect_ev(EV_INC, 12'h030);
      expect_ev(EV_LOAD, 12'h123);
      cyc(4);
      req("jnz_pc", S_PC, 12'h123);
      req("jnz_qempty", S_QSIZE, 12'h0);

      // JC with c=1 and three wait states per byte.
      c_flag = 1'b1;
      reset_to(12'h040, 3);
      expect_ev(EV_INC, 12'h040);
      expect_ev(EV_LOAD, 12'h7FE);
      cyc(1);
      req("jc_w0_memreq", S_MEMREQ, 12'h1);
      req("jc_w0_inc", S_INC, 12'h0);
      cyc(2);
      req("jc_w2_memreq", S_MEMREQ, 12'h1);
      req("jc_w2_inc", S_INC, 12'h0);
      cyc(1);
      req("jc_b1_inc", S_INC, 12'h1);
      cyc(1);
      req("jc_f2_memreq", S_MEMREQ, 12'h1);
      req("jc_f2_maddr", S_MADDR, 12'h041);
      req("jc_f2_load_wait", S_LOAD, 12'h0);
      cyc(3);
      req("jc_load", S_LOAD, 12'h1);
      req("jc_newaddr", S_NEWA, 12'h7FE);
      cyc(1);
      req("jc_pc", S_PC, 12'h7FE);
      req("jc_qempty", S_QSIZE, 12'h0);
      c_flag = 1'b0;

      // Stall held in EXEC, then PC wrap from 0xFFF.
      rom[12'hFFF] = 8'h3A; rom_def[12'hFFF] = 1'b1;
      rom[12'h000] = 8'h6B;
      stall = 1'b1;
      reset_to(12'hFFF, 0);
      expect_ev(EV_INC, 12'hFFF);
      expect_ev(EV_INSTR, 12'h13A);
      expect_ev(EV_INC, 12'h000);
      expect_ev(EV_INSTR, 12'h16B);
      cyc(1);
      req("wrap_inc", S_INC, 12'h1);
      cyc(1);
      req("st_e1_ival", S_IVAL, 12'h1);
      req("st_e1_phase", S_PHASE, 12'h1);
      req("wrap_pc0", S_PC, 12'h000);
      for (int i = 2; i <= 4; i++) begin
         cyc(1);
         req($sformatf("st_e%0d_phase", i), S_PHASE, 12'h1);
         req($sformatf("st_e%0d_ival", i), S_IVAL, 12'h0);
         req($sformatf("st_e%0d_memreq", i), S_MEMREQ, 12'h0);
      end
      stall = 1'b0;
      cyc(1);
      req("wrap_fetch_maddr", S_MADDR, 12'h000);
      req("wrap_fetch_phase", S_PHASE, 12'h0);
      cyc(1);
      req("wrap_instr", S_INSTR, 12'h6);
      req("wrap_oprnd", S_OPRND, 12'hB);
      cyc(1);
      req("wrap_pc1", S_PC, 12'h001);
      req("wrap_qempty", S_QSIZE, 12'h0);

      cyc(3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
